tf_addr_seq: RTL and testbench

Self-sequencing, parametrised twiddle-factor ROM address generator for the multi-stage radix-4 NTT/INTT datapath. It sits between the controller and the twiddle ROM. On a start pulse it walks every stage and every twiddle index on its own, and emits one or more registered ROM addresses per advancing cycle. It replaces the external stage/index inputs with an internal counter FSM and supports multiple lanes, a stall input and a parametrised stage count.

---
 rtl/tf_addr_seq_if.sv | 33 +++
 rtl/tf_addr_seq.sv | 151 +++++++++++++++
 tb/tb_tf_addr_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tf_addr_seq_if.sv
// tf_addr_seq_if - bundle between the NTT controller and tf_addr_seq.
//   master : controller side (drives start/inv/en, observes the address stream)
//   slave  : address generator side
// Signals:
//   start      request, accepted only while the generator is idle
//   inv        mode sampled with an accepted start (0 = NTT, 1 = INTT)
//   en         advance; 0 stalls the running sequence
//   tf_address LANES packed ROM addresses, lane i at [i*ADDR_W +: ADDR_W]
//   tf_valid   tf_address carries a new address set this cycle
//   done       one-cycle pulse with the final tf_valid
//   busy       generator is running
interface tf_addr_seq_if #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 1
);
  logic                      start;
  logic                      inv;
  logic                      en;
  logic [LANES*ADDR_W-1:0]   tf_address;
  logic                      tf_valid;
  logic                      done;
  logic                      busy;

  modport master (
    output start, inv, en,
    input  tf_address, tf_valid, done, busy
  );

  modport slave (
    input  start, inv, en,
    output tf_address, tf_valid, done, busy
  );
endinterface

// File: rtl/tf_addr_seq.sv
// tf_addr_seq - self-sequencing twiddle-factor ROM address generator for the
// multi-stage radix-4 NTT/INTT datapath. On an accepted start it walks every
// stage j (C_j = 2*4^j twiddles, base B_j = 2*(4^j-1)/3) and every index k in
// steps of LANES, emitting registered ROM addresses. NTT visits stages upward
// with ascending addresses; INTT visits stages downward with each stage mirrored.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts a run without a done pulse
//   bus  tf_addr_seq_if slave modport (start/inv/en in, address stream out)
module tf_addr_seq #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 8,
  parameter int LANES  = 1
) (
  input  logic          clk,
  input  logic          rst,
  tf_addr_seq_if.slave  bus
);

  localparam int TOTAL = 2 * (4 ** STAGES - 1) / 3;
  localparam int J_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
  // One spare bit so k+LANES and the stage size compare without overflow.
  localparam int C_W   = ADDR_W + 1;

  if (LANES != 1 && LANES != 2) begin : g_bad_lanes
    $error("tf_addr_seq: LANES must be 1 or 2");
  end
  if (longint'(TOTAL) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("tf_addr_seq: ADDR_W too small for the twiddle table");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic                      r_inv;
  logic [J_W-1:0]            r_j;
  logic [ADDR_W-1:0]         r_k;
  logic [LANES*ADDR_W-1:0]   r_addr;
  logic                      r_valid;
  logic                      r_done;
  logic                      r_busy;

  logic [C_W-1:0]            w_count;
  logic [C_W-1:0]            w_base;
  logic [C_W-1:0]            w_k_next;
  logic                      w_stage_end;
  logic                      w_last_stage;
  logic [LANES*ADDR_W-1:0]   w_addr;

  // Stage size C_j = 2*4^j.
  function automatic logic [C_W-1:0] f_count(input logic [J_W-1:0] j);
    logic [C_W-1:0] c;
    c = C_W'(2);
    for (int m = 0; m < STAGES; m++) begin
      if (m < int'(j)) c = c << 2;
    end
    return c;
  endfunction

  // Stage base B_j = sum of the sizes of all lower stages.
  function automatic logic [C_W-1:0] f_base(input logic [J_W-1:0] j);
    logic [C_W-1:0] b;
    logic [C_W-1:0] c;
    b = '0;
    c = C_W'(2);
    for (int m = 0; m < STAGES; m++) begin
      if (m < int'(j)) b = b + c;
      c = c << 2;
    end
    return b;
  endfunction

  assign w_count      = f_count(r_j);
  assign w_base       = f_base(r_j);
  assign w_k_next     = {1'b0, r_k} + C_W'(LANES);
  assign w_stage_end  = (w_k_next >= w_count);
  assign w_last_stage = r_inv ? (r_j == '0) : (r_j == J_W'(STAGES - 1));

  always_comb begin : p_lane_addr
    logic [C_W-1:0] idx;
    logic [C_W-1:0] a;
    w_addr = '0;
    idx    = '0;
    a      = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = {1'b0, r_k} + C_W'(i);
      // INTT mirrors the index inside the current stage.
      a   = r_inv ? (w_base + w_count - C_W'(1) - idx) : (w_base + idx);
      w_addr[i*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_inv   <= 1'b0;
      r_j     <= '0;
      r_k     <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_inv   <= bus.inv;
            r_k     <= '0;
            r_j     <= bus.inv ? J_W'(STAGES - 1) : '0;
          end
        end
        S_RUN: begin
          if (bus.en) begin
            r_addr  <= w_addr;
            r_valid <= 1'b1;
            if (!w_stage_end) begin
              r_k <= w_k_next[ADDR_W-1:0];
            end else begin
              r_k <= '0;
              if (w_last_stage) begin
                // done and the return to IDLE coincide with the final valid.
                r_done  <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_j <= r_inv ? (r_j - J_W'(1)) : (r_j + J_W'(1));
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tf_address = r_addr;
  assign bus.tf_valid   = r_valid;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_tf_addr_seq.sv
// Bench for tf_addr_seq: two instances (LANES=1 and LANES=2, defaults otherwise)
// share one stimulus. Whole sequences are captured and compared against a
// linear address model, then a table of spot vectors (stage boundaries, first
// and last addresses) is applied to the captured streams.
module tb_tf_addr_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inv = 1'b0;
  logic en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tf_addr_seq_if #(.ADDR_W(8), .LANES(1)) if1 ();
  tf_addr_seq_if #(.ADDR_W(8), .LANES(2)) if2 ();

  assign if1.start = start;
  assign if1.inv   = inv;
  assign if1.en    = en;
  assign if2.start = start;
  assign if2.inv   = inv;
  assign if2.en    = en;

  tf_addr_seq #(.STAGES(4), .ADDR_W(8), .LANES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  tf_addr_seq #(.STAGES(4), .ADDR_W(8), .LANES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  typedef struct {
    bit l2;        // 1: LANES=2 stream
    bit m;         // run mode the vector belongs to
    int idx;       // valid number within the run
    int exp_addr;  // packed expected tf_address
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  q1[$];
  logic [15:0] q2[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp1(input bit m, input int n);
    return m ? (169 - n) : n;
  endfunction

  function automatic int exp2(input bit m, input int n);
    int l0, l1;
    l0 = m ? (169 - 2 * n) : (2 * n);
    l1 = m ? (168 - 2 * n) : (2 * n + 1);
    return (l1 << 8) | l0;
  endfunction

  task automatic run(input bit m, input int stall_after, input int pulse_at,
                     input int rst_at);
    int  cyc;
    int  d1, d2;
    bit  fin1, fin2, stalled, aborted;
    q1.delete();
    q2.delete();
    d1 = 0; d2 = 0;
    fin1 = 0; fin2 = 0; stalled = 0; aborted = 0;
    start = 1'b1; inv = m; en = 1'b1;
    step();
    start = 1'b0; inv = 1'b0;
    check("busy_after_start", int'(if1.busy), 1);
    check("no_valid_after_start", int'(if1.tf_valid), 0);
    cyc = 0;
    while (cyc < 400 && !(fin1 && fin2) && !aborted) begin
      if (cyc == pulse_at) begin
        start = 1'b1; inv = ~m;
      end else begin
        start = 1'b0; inv = 1'b0;
      end
      step();
      cyc++;
      if (if1.tf_valid) begin
        q1.push_back(if1.tf_address);
        if (if1.done) begin
          d1++; fin1 = 1;
          check("done1_at_last", q1.size(), 170);
          check("busy1_low_at_done", int'(if1.busy), 0);
        end
      end else if (if1.done) begin
        d1++;
        check("done1_without_valid", 1, 0);
      end
      if (if2.tf_valid) begin
        q2.push_back(if2.tf_address);
        if (if2.done) begin
          d2++; fin2 = 1;
          check("done2_at_last", q2.size(), 85);
          check("busy2_low_at_done", int'(if2.busy), 0);
        end
      end else if (if2.done) begin
        d2++;
        check("done2_without_valid", 1, 0);
      end
      if (stall_after > 0 && !stalled && q1.size() == stall_after) begin
        stalled = 1;
        en = 1'b0;
        repeat (3) begin
          step();
          check("stall_no_valid", int'(if1.tf_valid), 0);
          check("stall_addr_hold", int'(if1.tf_address), stall_after - 1);
          check("stall_busy", int'(if1.busy), 1);
        end
        en = 1'b1;
      end
      if (rst_at > 0 && q1.size() == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        check("rst_valid1", int'(if1.tf_valid), 0);
        check("rst_addr1", int'(if1.tf_address), 0);
        check("rst_done1", int'(if1.done), 0);
        check("rst_busy1", int'(if1.busy), 0);
        check("rst_addr2", int'(if2.tf_address), 0);
        check("rst_busy2", int'(if2.busy), 0);
        step();
        check("rst_stays_idle", int'(if1.busy), 0);
        check("rst_no_done", int'(if1.done), 0);
        aborted = 1;
      end
    end
    start = 1'b0; inv = 1'b0;
    if (rst_at > 0) begin
      check("rst_valid_count", q1.size(), rst_at);
      check("rst_done_count", d1, 0);
    end else begin
      check("done1_seen", int'(fin1), 1);
      check("done2_seen", int'(fin2), 1);
      check("valid1_count", q1.size(), 170);
      check("valid2_count", q2.size(), 85);
      check("done1_count", d1, 1);
      check("done2_count", d2, 1);
    end
    foreach (q1[n]) check("addr1_seq", int'(q1[n]), exp1(m, n));
    foreach (q2[n]) check("addr2_seq", int'(q2[n]), exp2(m, n));
    if (rst_at <= 0) begin
      foreach (vecs[v]) begin
        if (vecs[v].m == m) begin
          if (vecs[v].l2) begin
            if (vecs[v].idx < q2.size()) check("vec2", int'(q2[vecs[v].idx]), vecs[v].exp_addr);
            else check("vec2_missing", q2.size(), vecs[v].idx + 1);
          end else begin
            if (vecs[v].idx < q1.size()) check("vec1", int'(q1[vecs[v].idx]), vecs[v].exp_addr);
            else check("vec1_missing", q1.size(), vecs[v].idx + 1);
          end
        end
      end
      step();
      check("idle_after_busy1", int'(if1.busy), 0);
      check("idle_after_valid1", int'(if1.tf_valid), 0);
    end
  endtask

  initial begin
    // {lanes2, mode, valid index, expected packed address}
    vecs.push_back('{0, 0, 0,   0});
    vecs.push_back('{0, 0, 1,   1});
    vecs.push_back('{0, 0, 2,   2});
    vecs.push_back('{0, 0, 42,  42});
    vecs.push_back('{0, 0, 169, 169});
    vecs.push_back('{0, 1, 0,   169});
    vecs.push_back('{0, 1, 127, 42});
    vecs.push_back('{0, 1, 128, 41});
    vecs.push_back('{0, 1, 159, 10});
    vecs.push_back('{0, 1, 160, 9});
    vecs.push_back('{0, 1, 167, 2});
    vecs.push_back('{0, 1, 168, 1});
    vecs.push_back('{0, 1, 169, 0});
    vecs.push_back('{1, 0, 0,   16'h0100});
    vecs.push_back('{1, 0, 84,  16'hA9A8});
    vecs.push_back('{1, 1, 0,   16'hA8A9});
    vecs.push_back('{1, 1, 84,  16'h0001});

    rst = 1'b1;
    repeat (3) step();
    check("reset_addr1", int'(if1.tf_address), 0);
    check("reset_valid1", int'(if1.tf_valid), 0);
    check("reset_done1", int'(if1.done), 0);
    check("reset_busy1", int'(if1.busy), 0);
    check("reset_addr2", int'(if2.tf_address), 0);
    check("reset_busy2", int'(if2.busy), 0);
    rst = 1'b0;
    step();
    check("idle_no_busy", int'(if1.busy), 0);

    run(1'b0, 0, -1, -1);   // NTT
    run(1'b1, 0, -1, -1);   // INTT
    run(1'b0, 5, -1, -1);   // stall after the 5th valid
    run(1'b1, 0, 20, -1);   // start with flipped inv mid-run
    run(1'b0, 0, -1, 50);   // reset at the 50th valid
    run(1'b0, 0, -1, -1);   // restart after reset
    check("restart_first_addr", (q1.size() > 0) ? int'(q1[0]) : -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
